// File: rtl/subtractor_pkg.sv
// Shared sizing constants for the adder/subtractor pair.
// The sum operand is one bit wider than the addends to hold the carry-out.
package subtractor_pkg;

  localparam int WIDTH_DEF = 8;

  function automatic int swidth_of(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/subtractor_pipe_stage.sv
// Single valid/ready register slice; loads when empty or draining in the same cycle.
// Zero-bubble at full throughput, data held stable while the consumer stalls.
module pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/subtractor.sv
// Recovers an addend from an adder sum: x = sm - y - cin, with sign/range flags.
// Two-stage valid/ready pipeline, 2-cycle latency, one result per cycle.
module subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int SWIDTH = swidth_of(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SWIDTH-1:0] sm,
  input  logic [WIDTH-1:0]  y,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  x,
  output logic              borrow,
  output logic              x_zero,
  output logic              fit_err
);

  localparam int S1W = SWIDTH + WIDTH + 1;
  localparam int S2W = WIDTH + 3;

  logic              s1_in_ready;
  logic              s1_valid;
  logic [S1W-1:0]    s1_dat;
  logic              s2_in_ready;
  logic [S2W-1:0]    s2_in_dat;
  logic [S2W-1:0]    s2_dat;

  logic [SWIDTH-1:0] s1_sm;
  logic [WIDTH-1:0]  s1_y;
  logic              s1_cin;
  logic [SWIDTH:0]   diff_d;
  logic [WIDTH-1:0]  x_d;
  logic              borrow_d;
  logic              zero_d;
  logic              fit_d;

  // Reset overrides any ready the slice would otherwise advertise.
  assign in_ready = s1_in_ready && !rst;

  pipe_stage #(.DW(S1W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && !rst),
    .in_ready  (s1_in_ready),
    .in_data   ({sm, y, cin}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_dat)
  );

  assign {s1_sm, s1_y, s1_cin} = s1_dat;

  // One extra bit above the sum width catches a negative difference.
  always_comb begin
    diff_d   = {1'b0, s1_sm}
             - {{(SWIDTH + 1 - WIDTH){1'b0}}, s1_y}
             - {{SWIDTH{1'b0}}, s1_cin};
    x_d      = diff_d[WIDTH-1:0];
    borrow_d = diff_d[SWIDTH];
    zero_d   = (diff_d == '0);
    fit_d    = !borrow_d && (diff_d[SWIDTH-1:WIDTH] != '0);
  end

  assign s2_in_dat = {x_d, borrow_d, zero_d, fit_d};

  pipe_stage #(.DW(S2W)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in_dat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_dat)
  );

  assign {x, borrow, x_zero, fit_err} = s2_dat;

endmodule

// File: tb/tb_subtractor.sv
// Directed bench for the subtractor: single vectors, stalled streaming, backpressure and reset.
module tb_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] sm;
  logic [7:0] y;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] x;
  logic       borrow;
  logic       x_zero;
  logic       fit_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  subtractor dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sm        (sm),
    .y         (y),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .borrow    (borrow),
    .x_zero    (x_zero),
    .fit_err   (fit_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {x, borrow, x_zero, fit_err}
  function automatic logic [10:0] res();
    return {x, borrow, x_zero, fit_err};
  endfunction

  task automatic send1(input string tag, input logic [8:0] a, input logic [7:0] b,
                       input logic c, input logic [10:0] exp);
    in_valid = 1'b1; sm = a; y = b; cin = c;
    tick();
    in_valid = 1'b0;
    #1;
    chk({tag, "_lat1_vld"}, out_valid, 0);
    tick();
    chk({tag, "_lat2_vld"}, out_valid, 1);
    chk({tag, "_res"}, res(), exp);
    tick();
    chk({tag, "_drained"}, out_valid, 0);
  endtask

  logic [10:0] held;
  logic        stall_prev;
  int          sent;
  int          rcv;
  logic [7:0]  exp_x;

  initial begin
    rst = 1'b1; in_valid = 1'b0; sm = '0; y = '0; cin = 1'b0; out_ready = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 0);
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", res(), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // x, borrow, x_zero, fit_err
    send1("v300_100", 9'd300, 8'd100, 1'b0, {8'd200, 1'b0, 1'b0, 1'b0});
    send1("v5_5_1",   9'd5,   8'd5,   1'b1, {8'hFF,  1'b1, 1'b0, 1'b0});
    send1("v5_4_1",   9'd5,   8'd4,   1'b1, {8'h00,  1'b0, 1'b1, 1'b0});
    send1("v511_0",   9'd511, 8'd0,   1'b0, {8'hFF,  1'b0, 1'b0, 1'b1});
    send1("wrap",     9'd0,   8'd0,   1'b1, {8'hFF,  1'b1, 1'b0, 1'b0});
    send1("v256_0",   9'd256, 8'd0,   1'b0, {8'h00,  1'b0, 1'b0, 1'b1});

    // Stream: sm = 30i+10, y = 20i, cin = i&1 -> x = 10(i+1) - (i&1)
    sent = 0; rcv = 0; stall_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      out_ready = (cyc % 2 == 0);
      in_valid  = (sent < 10);
      sm  = 9'(30 * sent + 10);
      y   = 8'(20 * sent);
      cin = sent[0];
      #1;
      if (stall_prev) chk("stream_hold", res(), held);
      if (out_valid && out_ready) begin
        exp_x = 8'(10 * (rcv + 1) - (rcv % 2));
        chk("stream_res", res(), {exp_x, 3'b000});
        rcv++;
      end
      stall_prev = out_valid && !out_ready;
      held = res();
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", rcv, 10);
    tick();
    tick();
    chk("stream_no_dup", out_valid, 0);

    // Fill both stages with the consumer stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; sm = 9'd50; y = 8'd10; cin = 1'b0;
    tick();
    sm = 9'd60; y = 8'd10;
    tick();
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_head", res(), {8'd40, 3'b000});
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    out_ready = 1'b0;
    #1;
    chk("restall_in_ready", in_ready, 0);

    // Reset with both stages full.
    rst = 1'b1;
    #1;
    chk("rst_hi_in_ready", in_ready, 0);
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_outputs", res(), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_no_stale", out_valid, 0);
    tick();
    chk("midrst_still_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
